mem_port_arbiter: RTL and testbench

Arbitrates the single main-memory port between the instruction-cache miss path and the data-cache miss/writeback path. It sits between the two cache controllers and the memory model, behind the MEM stage's dcache interface. It accepts one request at a time, holds it stable toward memory until accepted, and routes the read response back to the requester that issued it. Only one transaction is outstanding at any time.

---
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two cache miss paths, the arbiter and main memory.
// The arbiter uses the slave modport; the memory/cache side uses master.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
);
    logic                  ic_req_valid;
    logic [ADDR_W-1:0]     ic_req_addr;
    logic                  ic_req_ready;
    logic                  ic_resp_valid;
    logic [DATA_W-1:0]     ic_resp_data;

    logic                  dc_req_valid;
    logic                  dc_req_rw;
    logic [ADDR_W-1:0]     dc_req_addr;
    logic [DATA_W-1:0]     dc_req_wdata;
    logic [DATA_W/8-1:0]   dc_req_wmask;
    logic                  dc_req_ready;
    logic                  dc_resp_valid;
    logic [DATA_W-1:0]     dc_resp_data;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_req_rw;
    logic [ADDR_W-1:0]     mem_req_addr;
    logic [DATA_W-1:0]     mem_req_wdata;
    logic [DATA_W/8-1:0]   mem_req_wmask;
    logic                  mem_resp_valid;
    logic [DATA_W-1:0]     mem_resp_data;

    modport slave (
        input  ic_req_valid, ic_req_addr,
        output ic_req_ready, ic_resp_valid, ic_resp_data,
        input  dc_req_valid, dc_req_rw, dc_req_addr, dc_req_wdata, dc_req_wmask,
        output dc_req_ready, dc_resp_valid, dc_resp_data,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata, mem_req_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport master (
        output ic_req_valid, ic_req_addr,
        input  ic_req_ready, ic_resp_valid, ic_resp_data,
        output dc_req_valid, dc_req_rw, dc_req_addr, dc_req_wdata, dc_req_wmask,
        input  dc_req_ready, dc_resp_valid, dc_resp_data,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata, mem_req_wmask,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter for the main-memory port shared by icache and dcache.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise dcache has fixed priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]          state_q, state_d;
    logic                owner_q, owner_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wmask_q, wmask_d;
    logic                grant_ic_s;
    logic                grant_dc_s;
    logic                pick_dc_s;

`ifdef ARB_ROUND_ROBIN_EN
    // last_dc_q: 1 = dcache granted last, 0 = icache granted last
    logic                last_dc_q, last_dc_d;

    // Tie goes to the port not granted last; a lone requester always wins.
    always_comb begin
        pick_dc_s = bus.dc_req_valid && (!bus.ic_req_valid || !last_dc_q);
    end
`else
    // Fixed dcache priority.
    always_comb begin
        pick_dc_s = bus.dc_req_valid;
    end
`endif

    // Next-state, grant and request-latch logic.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        grant_ic_s = 1'b0;
        grant_dc_s = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_dc_d  = last_dc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // Gated by rst_n so no ready is shown while reset is asserted.
                if (rst_n && (bus.ic_req_valid || bus.dc_req_valid)) begin
                    state_d = ST_REQ;
                    if (pick_dc_s) begin
                        grant_dc_s = 1'b1;
                        owner_d    = 1'b1;
                        rw_d       = bus.dc_req_rw;
                        addr_d     = bus.dc_req_addr;
                        wdata_d    = bus.dc_req_wdata;
                        wmask_d    = bus.dc_req_wmask;
                    end else begin
                        grant_ic_s = 1'b1;
                        owner_d    = 1'b0;
                        rw_d       = 1'b0;
                        addr_d     = bus.ic_req_addr;
                        wdata_d    = {DATA_W{1'b0}};
                        wmask_d    = {(DATA_W/8){1'b0}};
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    last_dc_d = pick_dc_s;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.mem_req_ready) begin
                    state_d = rw_q ? ST_IDLE : ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (bus.mem_resp_valid) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, owner and latched request fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= {ADDR_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            wmask_q <= {(DATA_W/8){1'b0}};
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Last-grant pointer; resets to "icache last" so dcache wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_dc_q <= 1'b0;
        end else begin
            last_dc_q <= last_dc_d;
        end
    end
`endif

    assign bus.ic_req_ready  = grant_ic_s;
    assign bus.dc_req_ready  = grant_dc_s;
    assign bus.mem_req_valid = (state_q == ST_REQ);
    assign bus.mem_req_rw    = rw_q;
    assign bus.mem_req_addr  = addr_q;
    assign bus.mem_req_wdata = wdata_q;
    assign bus.mem_req_wmask = wmask_q;
    // Response strobe follows memory combinationally, steered by the owner bit.
    assign bus.ic_resp_valid = (state_q == ST_WAIT) && !owner_q && bus.mem_resp_valid;
    assign bus.dc_resp_valid = (state_q == ST_WAIT) &&  owner_q && bus.mem_resp_valid;
    assign bus.ic_resp_data  = bus.mem_resp_data;
    assign bus.dc_resp_data  = bus.mem_resp_data;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; inputs change 1 time unit
// after the rising edge, outputs are checked on the falling edge.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;
    logic exp_dc;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(128)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(128)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, ".mem_req_valid"}, 128'(bus.mem_req_valid), 128'd0);
        chk({tag, ".ic_req_ready"},  128'(bus.ic_req_ready),  128'd0);
        chk({tag, ".dc_req_ready"},  128'(bus.dc_req_ready),  128'd0);
        chk({tag, ".ic_resp_valid"}, 128'(bus.ic_resp_valid), 128'd0);
        chk({tag, ".dc_resp_valid"}, 128'(bus.dc_resp_valid), 128'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        bus.ic_req_valid   = 1'b0;
        bus.ic_req_addr    = 32'h0;
        bus.dc_req_valid   = 1'b0;
        bus.dc_req_rw      = 1'b0;
        bus.dc_req_addr    = 32'h0;
        bus.dc_req_wdata   = 128'h0;
        bus.dc_req_wmask   = 16'h0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = 128'h0;

        // Reset state
        @(negedge clk);
        check_idle_outputs("reset");
        chk("reset.mem_req_addr",  128'(bus.mem_req_addr),  128'd0);
        chk("reset.mem_req_wmask", 128'(bus.mem_req_wmask), 128'd0);
        chk("reset.mem_req_rw",    128'(bus.mem_req_rw),    128'd0);
        next_cycle();
        rst_n = 1'b1;

        // Single icache read
        bus.ic_req_valid = 1'b1;
        bus.ic_req_addr  = 32'h0000_1000;
        @(negedge clk);
        chk("ic_rd.ic_req_ready",  128'(bus.ic_req_ready),  128'd1);
        chk("ic_rd.dc_req_ready",  128'(bus.dc_req_ready),  128'd0);
        chk("ic_rd.mem_valid_T",   128'(bus.mem_req_valid), 128'd0);
        next_cycle();
        bus.ic_req_valid  = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        chk("ic_rd.mem_valid_T1",  128'(bus.mem_req_valid), 128'd1);
        chk("ic_rd.mem_rw",        128'(bus.mem_req_rw),    128'd0);
        chk("ic_rd.mem_wmask",     128'(bus.mem_req_wmask), 128'd0);
        chk("ic_rd.mem_addr",      128'(bus.mem_req_addr),  128'h1000);
        chk("ic_rd.ready_in_req",  128'(bus.ic_req_ready),  128'd0);
        next_cycle();
        bus.mem_req_ready = 1'b0;
        @(negedge clk);
        chk("ic_rd.mem_valid_T2",  128'(bus.mem_req_valid), 128'd0);
        chk("ic_rd.resp_T2",       128'(bus.ic_resp_valid), 128'd0);
        next_cycle();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 128'hDEADBEEF_00000000_00000000_00000000;
        @(negedge clk);
        chk("ic_rd.ic_resp_valid", 128'(bus.ic_resp_valid), 128'd1);
        chk("ic_rd.ic_resp_data",  bus.ic_resp_data, 128'hDEADBEEF_00000000_00000000_00000000);
        chk("ic_rd.dc_resp_valid", 128'(bus.dc_resp_valid), 128'd0);
        next_cycle();
        bus.mem_resp_valid = 1'b0;
        @(negedge clk);
        check_idle_outputs("ic_rd.after");

        // Dcache write with memory stalling for 4 cycles
        next_cycle();
        bus.dc_req_valid = 1'b1;
        bus.dc_req_rw    = 1'b1;
        bus.dc_req_addr  = 32'h0000_2040;
        bus.dc_req_wdata = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
        bus.dc_req_wmask = 16'h000F;
        @(negedge clk);
        chk("dc_wr.dc_req_ready", 128'(bus.dc_req_ready), 128'd1);
        chk("dc_wr.ic_req_ready", 128'(bus.ic_req_ready), 128'd0);
        next_cycle();
        bus.dc_req_valid = 1'b0;
        bus.dc_req_wdata = 128'h0;
        bus.dc_req_addr  = 32'h0;
        bus.dc_req_wmask = 16'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("dc_wr.stall_valid", 128'(bus.mem_req_valid), 128'd1);
            chk("dc_wr.stall_rw",    128'(bus.mem_req_rw),    128'd1);
            chk("dc_wr.stall_addr",  128'(bus.mem_req_addr),  128'h2040);
            chk("dc_wr.stall_wdata", bus.mem_req_wdata, 128'h01234567_89ABCDEF_FEDCBA98_76543210);
            chk("dc_wr.stall_wmask", 128'(bus.mem_req_wmask), 128'h000F);
            next_cycle();
        end
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        chk("dc_wr.accept_valid", 128'(bus.mem_req_valid), 128'd1);
        next_cycle();
        bus.mem_req_ready = 1'b0;
        @(negedge clk);
        check_idle_outputs("dc_wr.after");
        next_cycle();
        @(negedge clk);
        check_idle_outputs("dc_wr.no_resp");

        // Simultaneous reads, both held for three transactions (fresh pointer)
        next_cycle();
        do_reset();
        bus.ic_req_valid = 1'b1;
        bus.ic_req_addr  = 32'h0000_3000;
        bus.dc_req_valid = 1'b1;
        bus.dc_req_rw    = 1'b0;
        bus.dc_req_addr  = 32'h0000_4000;
        for (int i = 0; i < 3; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_dc = (i != 1);
`else
            exp_dc = 1'b1;
`endif
            @(negedge clk);
            chk("tie.dc_req_ready", 128'(bus.dc_req_ready), 128'(exp_dc));
            chk("tie.ic_req_ready", 128'(bus.ic_req_ready), 128'(!exp_dc));
            next_cycle();
            bus.mem_req_ready = 1'b1;
            @(negedge clk);
            chk("tie.mem_valid", 128'(bus.mem_req_valid), 128'd1);
            chk("tie.mem_addr",  128'(bus.mem_req_addr), exp_dc ? 128'h4000 : 128'h3000);
            chk("tie.ready_busy", 128'(bus.ic_req_ready | bus.dc_req_ready), 128'd0);
            next_cycle();
            bus.mem_req_ready  = 1'b0;
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = 128'(i + 7);
            @(negedge clk);
            chk("tie.dc_resp_valid", 128'(bus.dc_resp_valid), 128'(exp_dc));
            chk("tie.ic_resp_valid", 128'(bus.ic_resp_valid), 128'(!exp_dc));
            chk("tie.resp_data", exp_dc ? bus.dc_resp_data : bus.ic_resp_data, 128'(i + 7));
            next_cycle();
            bus.mem_resp_valid = 1'b0;
        end
        bus.ic_req_valid = 1'b0;
        bus.dc_req_valid = 1'b0;

        // Spurious mem_resp_valid in IDLE, then in REQ
        bus.mem_resp_valid = 1'b1;
        @(negedge clk);
        check_idle_outputs("spur_idle");
        next_cycle();
        bus.mem_resp_valid = 1'b0;
        bus.ic_req_valid   = 1'b1;
        bus.ic_req_addr    = 32'h0000_5000;
        @(negedge clk);
        chk("spur.grant", 128'(bus.ic_req_ready), 128'd1);
        next_cycle();
        bus.ic_req_valid   = 1'b0;
        bus.mem_resp_valid = 1'b1;
        @(negedge clk);
        chk("spur_req.mem_valid", 128'(bus.mem_req_valid), 128'd1);
        chk("spur_req.ic_resp",   128'(bus.ic_resp_valid), 128'd0);
        chk("spur_req.dc_resp",   128'(bus.dc_resp_valid), 128'd0);
        next_cycle();
        bus.mem_resp_valid = 1'b0;
        @(negedge clk);
        chk("spur_req.still_req", 128'(bus.mem_req_valid), 128'd1);
        next_cycle();
        bus.mem_req_ready = 1'b1;
        next_cycle();
        bus.mem_req_ready = 1'b0;

        // Asynchronous reset while in WAIT
        bus.mem_resp_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_wait");
        chk("rst_wait.mem_addr", 128'(bus.mem_req_addr), 128'd0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_rst.late_resp");
        next_cycle();
        bus.mem_resp_valid = 1'b0;
        bus.ic_req_valid   = 1'b1;
        bus.ic_req_addr    = 32'h0000_6000;
        @(negedge clk);
        chk("post_rst.ic_ready", 128'(bus.ic_req_ready), 128'd1);
        next_cycle();
        bus.ic_req_valid  = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        chk("post_rst.mem_valid", 128'(bus.mem_req_valid), 128'd1);
        chk("post_rst.mem_addr",  128'(bus.mem_req_addr),  128'h6000);
        next_cycle();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 128'h55;
        @(negedge clk);
        chk("post_rst.ic_resp", 128'(bus.ic_resp_valid), 128'd1);
        chk("post_rst.dc_resp", 128'(bus.dc_resp_valid), 128'd0);
        next_cycle();
        bus.mem_resp_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
